// File: rtl/mux4_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
//   Constants shared by the 4-way round-robin arbiter slice.
//   - NUM_REQ  : number of requesters served by the arbiter
//   - state_t  : arbiter state encoding (IDLE = output empty,
//                HOLD = output register holds an unconsumed transfer)
// ----------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage : mux4_rr_arbiter_pkg

// File: rtl/mux4_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter_if
//   Bundles the requester side and the downstream side of the arbiter.
//   Parameter size : payload width of every requester and of data_o.
//   Requester / consumer side (driven by the master modport):
//     req_i[3:0]          per-requester request
//     data0_i..data3_i    requester payloads, stable while requesting
//     ready_i             downstream accepts data_o this cycle
//   Arbiter side (driven by the slave modport):
//     grant_o[3:0]        one-hot combinational grant (capture cycle)
//     select_o[1:0]       index of requester currently on data_o
//     data_o              captured payload
//     valid_o             data_o holds an unconsumed transfer
//     count_o[15:0]       completed transfer count
// ----------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
   parameter int size = 32
);
   import mux4_rr_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req_i;
   logic [size-1:0]    data0_i;
   logic [size-1:0]    data1_i;
   logic [size-1:0]    data2_i;
   logic [size-1:0]    data3_i;
   logic               ready_i;

   logic [NUM_REQ-1:0] grant_o;
   logic [1:0]         select_o;
   logic [size-1:0]    data_o;
   logic               valid_o;
   logic [15:0]        count_o;

   // Requesters plus downstream consumer
   modport master (
      output req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
      input  grant_o, select_o, data_o, valid_o, count_o
   );

   // The arbiter itself
   modport slave (
      input  req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
      output grant_o, select_o, data_o, valid_o, count_o
   );

endinterface : mux4_rr_arbiter_if

// File: rtl/MUX_4to1.sv
// ----------------------------------------------------------------------------
// MUX_4to1
//   Plain combinational 4-to-1 multiplexer.
//   Parameter size : data width.
//   Ports:
//     data0_i..data3_i  candidate inputs
//     select_i[1:0]     index of the input routed to data_o
//     data_o            selected input
// ----------------------------------------------------------------------------
module MUX_4to1 #(
   parameter int size = 32
) (
   input  logic [size-1:0] data0_i,
   input  logic [size-1:0] data1_i,
   input  logic [size-1:0] data2_i,
   input  logic [size-1:0] data3_i,
   input  logic [1:0]      select_i,
   output logic [size-1:0] data_o
);

   always_comb begin
      data_o = data0_i;
      case (select_i)
         2'd0:    data_o = data0_i;
         2'd1:    data_o = data1_i;
         2'd2:    data_o = data2_i;
         default: data_o = data3_i;
      endcase
   end

endmodule : MUX_4to1

// File: rtl/mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter for four requesters feeding one registered output.
//   A payload is captured whenever the output register is free (IDLE) or is
//   being consumed this cycle (HOLD with ready_i), so a steady stream moves
//   one transfer per clock with no idle bubble.
//   Parameter size : payload width.
//   Ports:
//     clk_i   sole clock, rising edge
//     rst_i   synchronous active-high reset
//     bus     mux4_rr_arbiter_if slave modport (requests, payloads,
//             ready, grant, select, data, valid, transfer count)
// ----------------------------------------------------------------------------
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int size = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   mux4_rr_arbiter_if.slave   bus
);

   state_t             state_reg;
   state_t             state_next;
   logic [1:0]         last_reg;
   logic [1:0]         select_reg;
   logic [size-1:0]    data_reg;
   logic [15:0]        count_reg;

   logic [NUM_REQ-1:0] rot_req;
   logic [1:0]         pick_off;
   logic [1:0]         winner;
   logic               any_req;
   logic               capture_window;
   logic               do_capture;
   logic               accept;
   logic [NUM_REQ-1:0] grant;
   logic [size-1:0]    mux_data;

   assign any_req = |bus.req_i;

   // Output register is free this cycle. Reset suppresses it so no grant is
   // ever issued while rst_i is high.
   assign capture_window = !rst_i && ((state_reg == IDLE) || bus.ready_i);
   assign do_capture     = capture_window && any_req;
   assign accept         = (state_reg == HOLD) && bus.ready_i;

   // Rotate requests so that bit 0 is the requester right after the last
   // winner; the lowest set bit of the rotated vector is then the winner.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign rot_req[gi] = bus.req_i[last_reg + 2'(gi + 1)];
      end
   endgenerate

   always_comb begin
      pick_off = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_req[k]) begin
            pick_off = 2'(k);
         end
      end
   end

   assign winner = last_reg + pick_off + 2'd1;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
         assign grant[gi] = do_capture && (winner == 2'(gi));
      end
   endgenerate

   MUX_4to1 #(
      .size (size)
   ) u_mux (
      .data0_i  (bus.data0_i),
      .data1_i  (bus.data1_i),
      .data2_i  (bus.data2_i),
      .data3_i  (bus.data3_i),
      .select_i (winner),
      .data_o   (mux_data)
   );

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            // Without ready the held transfer stays put and requests wait.
            if (bus.ready_i) begin
               state_next = any_req ? HOLD : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture path: data/select/last only move on a capture edge, so they
   // keep their last value through backpressure and after draining to IDLE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_reg   <= '0;
         select_reg <= 2'd0;
         last_reg   <= 2'd3;
      end else if (do_capture) begin
         data_reg   <= mux_data;
         select_reg <= winner;
         last_reg   <= winner;
      end
   end

   // Completed transfer counter; wraps naturally at 16 bits. Reset takes
   // priority, so a transfer pending at reset is discarded uncounted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_reg <= 16'd0;
      end else if (accept) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign bus.grant_o  = grant;
   assign bus.select_o = select_reg;
   assign bus.data_o   = data_reg;
   assign bus.valid_o  = (state_reg == HOLD);
   assign bus.count_o  = count_reg;

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic        rdy;
      logic [3:0]  grant;
      logic        valid;
      logic [1:0]  sel;
      logic [31:0] data;
      logic [15:0] count;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[$];

   mux4_rr_arbiter_if #(.size(32)) bus ();

   mux4_rr_arbiter #(.size(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic y, input logic [3:0] g,
                      input logic v, input logic [1:0] s, input logic [31:0] d, input logic [15:0] c);
      vec_t t;
      t.rst = r; t.req = q; t.rdy = y; t.grant = g;
      t.valid = v; t.sel = s; t.data = d; t.count = c;
      vecs.push_back(t);
   endtask

   // Inputs change 1 time unit after a rising edge; checks happen 3 units
   // later, well before the next rising edge.
   task automatic drive(input logic r, input logic [3:0] q, input logic y);
      rst = r;
      bus.req_i = q;
      bus.ready_i = y;
      #3;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                          input logic [1:0] s, input logic [31:0] d, input logic [15:0] c);
      chk({tag, ".grant"}, 32'(bus.grant_o),  32'(g));
      chk({tag, ".valid"}, 32'(bus.valid_o),  32'(v));
      chk({tag, ".select"}, 32'(bus.select_o), 32'(s));
      chk({tag, ".data"},  bus.data_o,         d);
      chk({tag, ".count"}, 32'(bus.count_o),  32'(c));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.req_i = 4'b0000;
      bus.ready_i = 1'b0;
      bus.data0_i = 32'hA0;
      bus.data1_i = 32'hA1;
      bus.data2_i = 32'hA2;
      bus.data3_i = 32'hA3;

      //   rst req     rdy grant  vld sel data    count
      add(1, 4'hF, 1, 4'b0000, 0, 0, 32'h0,  0);   // second reset cycle
      add(0, 4'hF, 1, 4'b0001, 0, 0, 32'h0,  0);   // first grant after reset
      add(0, 4'hF, 1, 4'b0010, 1, 0, 32'hA0, 0);   // rotation, no bubble
      add(0, 4'hF, 1, 4'b0100, 1, 1, 32'hA1, 1);
      add(0, 4'hF, 1, 4'b1000, 1, 2, 32'hA2, 2);
      add(0, 4'hF, 1, 4'b0001, 1, 3, 32'hA3, 3);
      add(0, 4'h0, 1, 4'b0000, 1, 0, 32'hA0, 4);   // drain
      add(0, 4'h0, 1, 4'b0000, 0, 0, 32'hA0, 5);   // ready ignored in IDLE
      add(0, 4'h0, 1, 4'b0000, 0, 0, 32'hA0, 5);
      add(0, 4'h4, 0, 4'b0100, 0, 0, 32'hA0, 5);   // IDLE captures regardless of ready
      add(0, 4'h2, 0, 4'b0000, 1, 2, 32'hA2, 5);   // HOLD, req ignored
      add(0, 4'h0, 0, 4'b0000, 1, 2, 32'hA2, 5);   // req 1 dropped: no grant
      add(0, 4'h0, 1, 4'b0000, 1, 2, 32'hA2, 5);
      add(0, 4'h0, 0, 4'b0000, 0, 2, 32'hA2, 6);   // select holds in IDLE
      add(0, 4'h2, 1, 4'b0010, 0, 2, 32'hA2, 6);   // single persistent requester
      add(0, 4'h2, 1, 4'b0010, 1, 1, 32'hA1, 6);
      add(0, 4'h2, 1, 4'b0010, 1, 1, 32'hA1, 7);
      add(0, 4'h0, 0, 4'b0000, 1, 1, 32'hA1, 8);
      add(1, 4'hF, 1, 4'b0000, 1, 1, 32'hA1, 8);   // no grant during reset
      add(0, 4'hF, 1, 4'b0001, 0, 0, 32'h0,  0);   // pending discarded, uncounted
      add(0, 4'h0, 1, 4'b0000, 1, 0, 32'hA0, 0);
      add(0, 4'h0, 0, 4'b0000, 0, 0, 32'hA0, 1);   // valid falls after accept

      step();
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].rdy);
         chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid,
                 vecs[i].sel, vecs[i].data, vecs[i].count);
         $display("vec %0d: rst=%0b req=%b rdy=%0b -> grant=%b valid=%0b sel=%0d data=%0h count=%0d",
                  i, vecs[i].rst, vecs[i].req, vecs[i].rdy, bus.grant_o, bus.valid_o,
                  bus.select_o, bus.data_o, bus.count_o);
         step();
      end

      // Backpressure: hold requester 2's DEADBEEF, then rotate to 0.
      bus.data2_i = 32'hDEAD_BEEF;
      drive(0, 4'b0100, 0);
      chk("bp.grant2", 32'(bus.grant_o), 32'(4'b0100));
      step();
      for (int i = 0; i < 5; i++) begin
         drive(0, 4'b0011, 0);
         chk_out($sformatf("bp.hold%0d", i), 4'b0000, 1, 2, 32'hDEAD_BEEF, 1);
         step();
      end
      drive(0, 4'b0011, 1);
      chk("bp.grant0", 32'(bus.grant_o), 32'(4'b0001));
      step();
      drive(0, 4'b0000, 1);
      chk_out("bp.after", 4'b0000, 1, 0, 32'hA0, 2);
      $display("backpressure: select=%0d data=%0h count=%0d", bus.select_o, bus.data_o, bus.count_o);
      step();

      // Reset mid-HOLD with seven transfers counted.
      drive(1, 4'b0000, 0);
      step();
      for (int i = 0; i < 8; i++) begin
         drive(0, 4'b0001, 1);
         step();
      end
      drive(0, 4'b0000, 0);
      chk("rh.valid", 32'(bus.valid_o), 32'd1);
      chk("rh.count", 32'(bus.count_o), 32'd7);
      step();
      drive(1, 4'b1111, 1);
      chk("rh.nogrant", 32'(bus.grant_o), 32'd0);
      step();
      drive(0, 4'b1111, 0);
      chk_out("rh.after", 4'b0001, 0, 0, 32'h0, 0);
      $display("reset mid-hold: valid=%0b count=%0d grant=%b", bus.valid_o, bus.count_o, bus.grant_o);
      step();

      // Counter wrap: 65535 accepts then one more.
      drive(1, 4'b0000, 0);
      step();
      for (int i = 0; i < 65536; i++) begin
         drive(0, 4'b1111, 1);
         step();
      end
      drive(0, 4'b1111, 0);
      chk("wrap.ffff", 32'(bus.count_o), 32'h0000_FFFF);
      $display("wrap: count=%0h", bus.count_o);
      step();
      drive(0, 4'b1111, 1);
      step();
      drive(0, 4'b0000, 0);
      chk("wrap.zero", 32'(bus.count_o), 32'h0);
      $display("wrap: count=%0h", bus.count_o);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mux4_rr_arbiter
